// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared datapath with one memory port.
// Strobes are combinational from state/class; the memory stalls by holding mem_ready low, with an optional timeout.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned TO_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 branch,
  output logic                 pc_src,
  output logic [1:0]           alu_src_a,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 reg_write,
  output logic                 illegal,
  output logic                 timeout,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
  } class_e;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(MEM_TIMEOUT);

  state_e                state_q, state_d;
  class_e                cls_q, cls_d, dec_cls;
  logic [TO_WIDTH-1:0]   wait_q, wait_d, wait_inc;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;
  logic                  illegal_q, illegal_d;
  logic                  timeout_q, timeout_d;
  logic                  retire;

  always_comb begin
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BR;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      default:    dec_cls = C_ILLEGAL;
    endcase
  end

  assign wait_inc = wait_q + TO_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    wait_d     = wait_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    result_src = 2'b00;
    reg_write  = 1'b0;
    busy       = 1'b1;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          wait_d   = '0;
          state_d  = S_DECODE;
        end else begin
          wait_d = wait_inc;
          if (MEM_TIMEOUT != 0 && wait_inc == TO_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = S_FAULT;
          end
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == C_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = S_FAULT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (cls_q)
          C_R:     alu_op = 2'b10;
          C_I: begin
            alu_op    = 2'b01;
            alu_src_b = 1'b1;
          end
          C_LOAD, C_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          C_BR: begin
            alu_op  = 2'b11;
            branch  = 1'b1;
            pc_src  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_JAL, C_JALR: begin
            alu_src_a = (cls_q == C_JAL) ? 2'b01 : 2'b00;
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
          end
          C_LUI: begin
            alu_src_a = 2'b10;
            alu_src_b = 1'b1;
          end
          C_AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls_q == C_STORE);
        if (mem_ready) begin
          wait_d = '0;
          if (cls_q == C_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_d = wait_inc;
          if (MEM_TIMEOUT != 0 && wait_inc == TO_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = S_FAULT;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        if (cls_q == C_LOAD) begin
          result_src = 2'b01;
        end else if (cls_q == C_JAL || cls_q == C_JALR) begin
          result_src = 2'b10;
        end
      end
      default: busy = 1'b0;
    endcase

    // Every fresh memory request starts its wait count from zero.
    if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
      wait_d = '0;
    end
  end

  assign retired_d = retire ? retired_q + CNT_WIDTH'(1) : retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NONE;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign retired = retired_q;

endmodule
